reset_sequencer: RTL and testbench

Parametrised reset controller for the board top level, feeding all downstream logic (UART, register interface, motor-control datapath). Power-on hold, debounced reset requests from several active-low key/pin sources plus a software request from the register file. Staged, ordered release of `NUM_STAGES` reset domains, with a sticky reset-cause register readable over the UART register interface.

---
 rtl/reset_sequencer_pkg.sv | 28 ++
 rtl/reset_debouncer.sv | 59 +++++
 rtl/reset_sequencer.sv | 135 +++++++++++++
 tb/tb_reset_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reset_sequencer_pkg : shared types, cause-bit indices and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } seq_state_e;

   localparam int CAUSE_POR = 0;

   // Software cause sits just above the hardware source bits.
   function automatic int CAUSE_SW(input int num_sources);
      return num_sources + 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reset_debouncer.sv
// ---------------------------------------------------------------------------
// reset_debouncer : 2-FF synchroniser plus debounce for one active-low pin
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_debouncer
   import reset_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clock,
   input  logic srst,
   input  logic req_n,
   output logic active
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = req_n;
      sync2_d  = sync1_q;
      active_d = active_q;
      cnt_d    = '0;
      // The DEBOUNCE_CYCLES-th consecutive differing cycle flips the level.
      if ((~sync2_q) != active_q) begin
         if (cnt_q == CNT_LAST) begin
            active_d = ~active_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge srst) begin
      if (srst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   assign active = active_q;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer : power-on hold and ordered release of reset domains
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int POR_CYCLES      = 25_000_000,
   parameter int NUM_STAGES      = 4,
   parameter int STAGE_CYCLES    = 1000,
   parameter int NUM_SOURCES     = 2,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic                   clock,
   input  logic                   srst,
   input  logic [NUM_SOURCES-1:0] rst_req_n,
   input  logic                   sw_rst_req,
   input  logic                   cause_clear,
   output logic [NUM_STAGES-1:0]  stage_rst,
   output logic                   all_released,
   output logic [NUM_SOURCES+1:0] cause
);

   localparam int               CNT_W      = $clog2(max_int(POR_CYCLES, STAGE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
   localparam int               SW_BIT     = CAUSE_SW(NUM_SOURCES);

   logic [NUM_SOURCES-1:0] src_active;
   logic                   req;
   logic                   release_now;
   logic [NUM_STAGES-1:0]  stage_shift;
   logic [NUM_SOURCES+1:0] cause_set;

   seq_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
   logic                   all_released_q, all_released_d;
   logic [NUM_SOURCES+1:0] cause_q, cause_d;

   for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
      reset_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clock (clock),
         .srst  (srst),
         .req_n (rst_req_n[i]),
         .active(src_active[i])
      );
   end

   assign req = (|src_active) | sw_rst_req;

   // Stages clear in ascending order, so shifting zeros in from the LSB
   // releases the next one; an all-zero result means the last has gone.
   assign stage_shift = stage_rst_q << 1;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stage_rst_d    = stage_rst_q;
      all_released_d = all_released_q;
      release_now    = 1'b0;

      if (req) begin
         state_d        = HOLD;
         cnt_d          = '0;
         stage_rst_d    = '1;
         all_released_d = 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == POR_LAST) release_now = 1'b1;
               else                   cnt_d       = cnt_q + 1'b1;
            end
            RELEASE: begin
               if (cnt_q == STAGE_LAST) release_now = 1'b1;
               else                     cnt_d       = cnt_q + 1'b1;
            end
            RUN: ;
            default: begin
               state_d        = HOLD;
               cnt_d          = '0;
               stage_rst_d    = '1;
               all_released_d = 1'b0;
            end
         endcase

         if (release_now) begin
            cnt_d       = '0;
            stage_rst_d = stage_shift;
            if (stage_shift == '0) begin
               state_d        = RUN;
               all_released_d = 1'b1;
            end else begin
               state_d = RELEASE;
            end
         end
      end
   end

   // A set arriving with a clear wins, so sets are OR-ed in after clearing.
   always_comb begin
      cause_set                 = '0;
      cause_set[NUM_SOURCES:1]  = src_active;
      cause_set[SW_BIT]         = sw_rst_req;
      cause_d                   = (cause_clear ? '0 : cause_q) | cause_set;
   end

   always_ff @(posedge clock or posedge srst) begin
      if (srst) begin
         state_q              <= HOLD;
         cnt_q                <= '0;
         stage_rst_q          <= '1;
         all_released_q       <= 1'b0;
         cause_q              <= '0;
         cause_q[CAUSE_POR]   <= 1'b1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stage_rst_q    <= stage_rst_d;
         all_released_q <= all_released_d;
         cause_q        <= cause_d;
      end
   end

   assign stage_rst    = stage_rst_q;
   assign all_released = all_released_q;
   assign cause        = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer : directed self-checking bench for reset_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reset_sequencer;

   logic       clock = 1'b0;
   logic       srst  = 1'b0;
   logic [1:0] rst_req_n = 2'b11;
   logic       sw_rst_req = 1'b0;
   logic       cause_clear = 1'b0;
   logic [2:0] stage_rst;
   logic       all_released;
   logic [3:0] cause;

   int n_cmp = 0;
   int n_err = 0;

   reset_sequencer #(
      .POR_CYCLES     (10),
      .NUM_STAGES     (3),
      .STAGE_CYCLES   (4),
      .NUM_SOURCES    (2),
      .DEBOUNCE_CYCLES(5)
   ) dut (
      .clock       (clock),
      .srst        (srst),
      .rst_req_n   (rst_req_n),
      .sw_rst_req  (sw_rst_req),
      .cause_clear (cause_clear),
      .stage_rst   (stage_rst),
      .all_released(all_released),
      .cause       (cause)
   );

   always #5 clock = ~clock;

   task automatic test_reset();
      #1 srst = 1'b1;
      #2;
      n_cmp++;
      if (stage_rst !== 3'b111) begin n_err++; $display("FAIL reset_stage: got %b want 111", stage_rst); end
      n_cmp++;
      if (all_released !== 1'b0) begin n_err++; $display("FAIL reset_all: got %b want 0", all_released); end
      n_cmp++;
      if (cause !== 4'b0001) begin n_err++; $display("FAIL reset_cause: got %b want 0001", cause); end
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (stage_rst !== 3'b111) begin n_err++; $display("FAIL reset_hold_stage: got %b want 111", stage_rst); end
   endtask

   task automatic test_power_on();
      logic [2:0] exp_stage;
      @(negedge clock) srst = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clock); #1;
         exp_stage = {k < 18, k < 14, k < 10};
         n_cmp++;
         if (stage_rst !== exp_stage) begin n_err++; $display("FAIL po_stage edge %0d: got %b want %b", k, stage_rst, exp_stage); end
         n_cmp++;
         if (all_released !== (k >= 18)) begin n_err++; $display("FAIL po_all edge %0d: got %b want %b", k, all_released, k >= 18); end
      end
      n_cmp++;
      if (cause !== 4'b0001) begin n_err++; $display("FAIL po_cause: got %b want 0001", cause); end
   endtask

   task automatic test_glitch();
      @(negedge clock) rst_req_n[0] = 1'b0;
      repeat (4) @(negedge clock);
      rst_req_n[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (stage_rst !== 3'b000 || all_released !== 1'b1) begin
            n_err++; $display("FAIL glitch_out cyc %0d: got %b/%b want 000/1", k, stage_rst, all_released);
         end
         n_cmp++;
         if (cause !== 4'b0001) begin n_err++; $display("FAIL glitch_cause cyc %0d: got %b want 0001", k, cause); end
      end
   endtask

   task automatic test_key_reset();
      @(negedge clock) cause_clear = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if (cause !== 4'b0000) begin n_err++; $display("FAIL key_clear: got %b want 0000", cause); end
      @(negedge clock) begin cause_clear = 1'b0; rst_req_n[1] = 1'b0; end
      for (int k = 0; k <= 44; k++) begin
         @(posedge clock); #1;
         if (k == 6) begin
            n_cmp++;
            if (stage_rst !== 3'b000 || cause !== 4'b0000) begin
               n_err++; $display("FAIL key_pre E+6: got %b/%b want 000/0000", stage_rst, cause);
            end
         end
         if (k == 7) begin
            n_cmp++;
            if (stage_rst !== 3'b111 || all_released !== 1'b0) begin
               n_err++; $display("FAIL key_assert E+7: got %b/%b want 111/0", stage_rst, all_released);
            end
            n_cmp++;
            if (cause !== 4'b0100) begin n_err++; $display("FAIL key_cause E+7: got %b want 0100", cause); end
         end
         if (k == 35) begin
            n_cmp++;
            if (stage_rst !== 3'b111) begin n_err++; $display("FAIL key_hold E+35: got %b want 111", stage_rst); end
         end
         if (k == 36) begin
            n_cmp++;
            if (stage_rst !== 3'b110) begin n_err++; $display("FAIL key_rel0 E+36: got %b want 110", stage_rst); end
         end
         if (k == 40) begin
            n_cmp++;
            if (stage_rst !== 3'b100) begin n_err++; $display("FAIL key_rel1 E+40: got %b want 100", stage_rst); end
         end
         if (k == 43) begin
            n_cmp++;
            if (stage_rst !== 3'b100 || all_released !== 1'b0) begin
               n_err++; $display("FAIL key_pre2 E+43: got %b/%b want 100/0", stage_rst, all_released);
            end
         end
         if (k == 44) begin
            n_cmp++;
            if (stage_rst !== 3'b000 || all_released !== 1'b1) begin
               n_err++; $display("FAIL key_run E+44: got %b/%b want 000/1", stage_rst, all_released);
            end
            n_cmp++;
            if (cause !== 4'b0100) begin n_err++; $display("FAIL key_cause_end: got %b want 0100", cause); end
         end
         if (k == 19) @(negedge clock) rst_req_n[1] = 1'b1;
      end
   endtask

   task automatic test_sw_mid_release();
      bit done;
      @(negedge clock) sw_rst_req = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if (stage_rst !== 3'b111 || cause[3] !== 1'b1) begin
         n_err++; $display("FAIL sw_first: got %b/%b want 111/1", stage_rst, cause[3]);
      end
      @(negedge clock) sw_rst_req = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clock); #1;
         if (k == 6) begin
            n_cmp++;
            if (cause !== 4'b0000) begin n_err++; $display("FAIL sw_clear: got %b want 0000", cause); end
         end
         if (k == 9) begin
            n_cmp++;
            if (stage_rst !== 3'b111) begin n_err++; $display("FAIL sw_hold S+9: got %b want 111", stage_rst); end
         end
         if (k == 10 || k == 13) begin
            n_cmp++;
            if (stage_rst !== 3'b110) begin n_err++; $display("FAIL sw_rel0 S+%0d: got %b want 110", k, stage_rst); end
         end
         @(negedge clock);
         cause_clear = (k == 4);
         sw_rst_req  = (k == 13);
      end
      @(posedge clock); #1;
      n_cmp++;
      if (stage_rst !== 3'b111 || all_released !== 1'b0) begin
         n_err++; $display("FAIL sw_collide_edge S+14: got %b/%b want 111/0", stage_rst, all_released);
      end
      n_cmp++;
      if (cause !== 4'b1000) begin n_err++; $display("FAIL sw_cause S+14: got %b want 1000", cause); end
      @(negedge clock) sw_rst_req = 1'b0;
      for (int k = 15; k <= 24; k++) begin
         @(posedge clock); #1;
         if (k == 23) begin
            n_cmp++;
            if (stage_rst !== 3'b111) begin n_err++; $display("FAIL sw_hold S+23: got %b want 111", stage_rst); end
         end
         if (k == 24) begin
            n_cmp++;
            if (stage_rst !== 3'b110) begin n_err++; $display("FAIL sw_rel0 S+24: got %b want 110", stage_rst); end
         end
      end
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(posedge clock); #1;
         done = all_released;
      end
      n_cmp++;
      if (!done || stage_rst !== 3'b000) begin
         n_err++; $display("FAIL sw_to_run: got done=%b stage=%b want 1/000", done, stage_rst);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clock);
      #3 srst = 1'b1;
      #1;
      n_cmp++;
      if (stage_rst !== 3'b111 || all_released !== 1'b0) begin
         n_err++; $display("FAIL async_out: got %b/%b want 111/0", stage_rst, all_released);
      end
      n_cmp++;
      if (cause !== 4'b0001) begin n_err++; $display("FAIL async_cause: got %b want 0001", cause); end
      @(negedge clock) srst = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clock); #1;
         if (k == 9 || k == 10 || k == 14 || k == 17 || k == 18) begin
            logic [2:0] exp_stage;
            exp_stage = {k < 18, k < 14, k < 10};
            n_cmp++;
            if (stage_rst !== exp_stage || all_released !== (k >= 18)) begin
               n_err++; $display("FAIL async_seq edge %0d: got %b/%b want %b/%b", k, stage_rst, all_released, exp_stage, k >= 18);
            end
         end
      end
   endtask

   task automatic test_collision();
      @(negedge clock) begin cause_clear = 1'b1; sw_rst_req = 1'b1; end
      @(posedge clock); #1;
      n_cmp++;
      if (cause !== 4'b1000) begin n_err++; $display("FAIL collide_cause: got %b want 1000", cause); end
      n_cmp++;
      if (stage_rst !== 3'b111 || all_released !== 1'b0) begin
         n_err++; $display("FAIL collide_out: got %b/%b want 111/0", stage_rst, all_released);
      end
      @(negedge clock) begin cause_clear = 1'b0; sw_rst_req = 1'b0; end
      @(posedge clock); #1;
      n_cmp++;
      if (cause !== 4'b1000) begin n_err++; $display("FAIL collide_sticky: got %b want 1000", cause); end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_glitch();
      test_key_reset();
      test_sw_mid_release();
      test_async_reset();
      test_collision();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
